det_seq_ctrl: RTL and testbench
===============================

Name: det_seq_ctrl

Overview:
- Sequential determinant controller for the matrix coprocessor.
- Accepts a packed 5x5 signed 8-bit matrix and a size (1..5).
- Time-shares a single combinational 4x4 determinant unit across the five first-row cofactor minors, instead of instantiating five copies.
- Sits between the instruction/command decoder and the result register bank; uses a start/busy/done handshake.

Parameters:
- ELEM_W, 8, element width (signed)
- DIM, 5, maximum matrix order
- DET_W, 32, result width (signed, modulo 2^DET_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- size  in  3  matrix order; valid 1..5
- matriz_in  in  200  packed matrix, row-major, MSB first; element (r,c) at [199-8*(5r+c) -: 8]
- busy  out  1  high while a computation is in flight
- done  out  1  one-cycle pulse when det_out is updated
- error  out  1  one-cycle pulse on invalid size
- det_out  out  32  signed determinant; held until the next accepted start

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, col=0, acc=0, det4_q=0, busy=0, done=0, error=0, det_out=0.
- States:
  - IDLE
  - DIRECT (size 1..4)
  - MINOR (size 5, col 0..4)
  - DRAIN
- IDLE transitions:
  - On start with size in 1..5: latch matriz_in and size into m_q, clear acc, set busy=1.
  - Then go to DIRECT if size<=4, or to MINOR with col=0 if size==5.
- Invalid size (0, 6, 7) with start:
  - error=1 for one cycle, det_out=0, done=0, busy stays 0, state stays IDLE.
- DIRECT:
  - Builds a 4x4 operand from m_q: top-left size x size block kept.
  - All other positions replaced by identity (1 on diagonal, 0 elsewhere).
  - Out-of-order elements of matriz_in are therefore ignored.
  - Edge 1: det4_q <= det4(operand). Edge 2: det_out <= det4_q, done=1, busy=0, state -> IDLE.
  - Latency: done high 2 cycles after the start-sampling edge.
- MINOR (2-stage pipeline):
  - Each edge: det4_q <= det4(minor(col)), where minor(col) removes row 0 and column col.
  - coef_q <= m_q(0,col); sign_q <= col[0].
  - From the second MINOR edge onward, acc <= acc ± coef_q*det4_q: + when sign_q=0, - when sign_q=1.
  - col increments 0..4; after col=4, state -> DRAIN.
- DRAIN:
  - det_out <= acc ± coef_q*det4_q (final term), done=1, busy=0, state -> IDLE.
  - Latency: done high 6 cycles after the start-sampling edge; busy high for those 6 cycles.
- Arithmetic:
  - Product is 8x32 signed, computed at 40 bits.
  - acc and det_out keep the low 32 bits (two's-complement wrap).
  - Result is bit-identical to the combinational 5x5 determinant.
- start while busy: ignored; no queuing.
- start in the done cycle: state is already IDLE, so it is accepted (back-to-back, no bubble).
- matriz_in may change freely after the start-sampling edge.
- rst mid-operation: all registers return to reset values next edge; no done pulse; det_out=0.

Decomposition:
- Shared package det_pkg holds:
  - ELEM_W, DIM, DET_W
  - State enum {IDLE, DIRECT, MINOR, DRAIN}
  - Function elem(m,r,c)
  - Function minor4(m,col)
  - Function pad4(m,size)
- Sub-module: existing determinante_4x4, instantiated once. Its operand is muxed from minor4/pad4 by state.

Test Plan:
- Identity 5x5, size=5, start one cycle -> busy high 6 cycles, done pulse at cycle 6, det_out=1.
- diag(2,3,-1,4,5), size=5 -> det_out=-120 (0xFFFFFF88); then a second start in the done cycle with identity -> det_out=1 six cycles later.
- size=3, top-left [[2,0,1],[1,3,2],[1,1,2]], remaining elements 0x7F -> done after 2 cycles, det_out=6.
- diag(127 x5), size=5 -> det_out=-1321368961 (127^5 mod 2^32, signed); non-diagonal minor elements checked against software model on 1000 random matrices.
- size=6 with start -> error pulse 1 cycle, det_out=0, busy=0. Then start pulsed on cycle 2 of a size=5 job -> ignored, result of the first job unchanged.
- rst asserted on cycle 3 of a size=5 job -> next edge busy=0, det_out=0, no done. A fresh start with diag(2,3,-1,4,5) then yields -120.

Source files
------------

// File: rtl/det_pkg.sv
// Shared types and helpers for the sequential determinant controller.
// Matrices are packed row-major, MSB first.
package det_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int DET_W  = 32;

  localparam int MAT_W  = DIM * DIM * ELEM_W;
  localparam int M4_W   = 16 * ELEM_W;
  localparam int MAT_IW = $clog2(MAT_W);
  localparam int M4_IW  = $clog2(M4_W);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    MINOR,
    DRAIN
  } state_t;

  typedef logic [MAT_W-1:0] mat5_t;
  typedef logic [M4_W-1:0]  mat4_t;

  function automatic logic signed [ELEM_W-1:0] elem(
    input mat5_t m,
    input int    r,
    input int    c
  );
    return m[MAT_IW'(MAT_W-1-ELEM_W*(DIM*r+c)) -: ELEM_W];
  endfunction

  function automatic mat4_t minor4(
    input mat5_t      m,
    input logic [2:0] col
  );
    mat4_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[M4_IW'(M4_W-1-ELEM_W*(4*r+c)) -: ELEM_W] =
          elem(m, r + 1, (c < int'(col)) ? c : c + 1);
      end
    end
    return o;
  endfunction

  // Orders below four are embedded in an identity so det4 equals their det.
  function automatic mat4_t pad4(
    input mat5_t      m,
    input logic [2:0] size
  );
    mat4_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r < int'(size) && c < int'(size))
          o[M4_IW'(M4_W-1-ELEM_W*(4*r+c)) -: ELEM_W] = elem(m, r, c);
        else if (r == c)
          o[M4_IW'(M4_W-1-ELEM_W*(4*r+c)) -: ELEM_W] = ELEM_W'(1);
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/determinante_4x4.sv
// Combinational 4x4 signed determinant, wrapping modulo 2^DET_W.
// Cofactor expansion along row 0.
module determinante_4x4
  import det_pkg::*;
(
  input  logic [M4_W-1:0]         matriz_in,
  output logic signed [DET_W-1:0] det_out
);

  logic signed [DET_W-1:0] a [4][4];

  function automatic logic signed [DET_W-1:0] d3(
    input logic signed [DET_W-1:0] p, q, s,
    input logic signed [DET_W-1:0] t, u, v,
    input logic signed [DET_W-1:0] x, y, z
  );
    return p * (u * z - v * y)
         - q * (t * z - v * x)
         + s * (t * y - u * x);
  endfunction

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a[r][c] = DET_W'($signed(
          matriz_in[M4_IW'(M4_W-1-ELEM_W*(4*r+c)) -: ELEM_W]));
      end
    end
  end

  assign det_out =
      a[0][0] * d3(a[1][1], a[1][2], a[1][3],
                   a[2][1], a[2][2], a[2][3],
                   a[3][1], a[3][2], a[3][3])
    - a[0][1] * d3(a[1][0], a[1][2], a[1][3],
                   a[2][0], a[2][2], a[2][3],
                   a[3][0], a[3][2], a[3][3])
    + a[0][2] * d3(a[1][0], a[1][1], a[1][3],
                   a[2][0], a[2][1], a[2][3],
                   a[3][0], a[3][1], a[3][3])
    - a[0][3] * d3(a[1][0], a[1][1], a[1][2],
                   a[2][0], a[2][1], a[2][2],
                   a[3][0], a[3][1], a[3][2]);

endmodule

// File: rtl/det_seq_ctrl.sv
// Sequential determinant controller: one shared 4x4 unit, time-shared
// over the five row-0 minors for order 5, used directly for orders 1..4.
module det_seq_ctrl
  import det_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              size,
  input  logic [MAT_W-1:0]        matriz_in,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic signed [DET_W-1:0] det_out
);

  state_t                  r_state;
  state_t                  w_next;
  logic [2:0]              r_col;
  logic [2:0]              r_size;
  mat5_t                   r_m;
  logic signed [DET_W-1:0] r_acc;
  logic signed [DET_W-1:0] r_det4;
  logic signed [ELEM_W-1:0] r_coef;
  logic                    r_sign;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_error;
  logic signed [DET_W-1:0] r_det_out;

  mat4_t                   w_op;
  logic signed [DET_W-1:0] w_det4;
  logic signed [DET_W-1:0] w_coef;
  logic signed [DET_W-1:0] w_prod;
  logic signed [DET_W-1:0] w_term;
  logic                    w_ok;

  assign w_ok = (size != 3'd0) && (size <= 3'd5);
  assign w_op = (r_state == MINOR) ? minor4(r_m, r_col)
                                   : pad4(r_m, r_size);

  determinante_4x4 u_det4 (
    .matriz_in (w_op),
    .det_out   (w_det4)
  );

  // Only the low DET_W bits of the widened product survive the wrap.
  assign w_coef = {{(DET_W-ELEM_W){r_coef[ELEM_W-1]}}, r_coef};
  assign w_prod = w_coef * r_det4;
  assign w_term = r_sign ? r_acc - w_prod : r_acc + w_prod;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start && w_ok)
                w_next = (size == 3'd5) ? MINOR : DIRECT;
      DIRECT: if (r_col == 3'd1) w_next = IDLE;
      MINOR:  if (r_col == 3'd4) w_next = DRAIN;
      DRAIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_size    <= '0;
      r_m       <= '0;
      r_acc     <= '0;
      r_det4    <= '0;
      r_coef    <= '0;
      r_sign    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_det_out <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start && w_ok) begin
            r_m    <= matriz_in;
            r_size <= size;
            r_acc  <= '0;
            r_col  <= '0;
            r_busy <= 1'b1;
          end else if (start) begin
            r_error   <= 1'b1;
            r_det_out <= '0;
          end
        end
        DIRECT: begin
          if (r_col == 3'd0) begin
            r_det4 <= w_det4;
            r_col  <= 3'd1;
          end else begin
            r_det_out <= r_det4;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_col     <= '0;
          end
        end
        MINOR: begin
          r_det4 <= w_det4;
          r_coef <= elem(r_m, 0, int'(r_col));
          r_sign <= r_col[0];
          if (r_col != 3'd0) r_acc <= w_term;
          r_col <= (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
        end
        DRAIN: begin
          r_det_out <= w_term;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign error   = r_error;
  assign det_out = r_det_out;

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Scoreboard bench for det_seq_ctrl: expected determinants are queued
// at start and compared when done pulses.
module tb_det_seq_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [2:0]         size = 3'd0;
  logic [199:0]       matriz_in = '0;
  logic               busy;
  logic               done;
  logic               error;
  logic signed [31:0] det_out;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_done = 0;
  logic [31:0] sb [$];

  det_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .size      (size),
    .matriz_in (matriz_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .det_out   (det_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [199:0] put(input logic [199:0] m, input int r,
                                       input int c, input logic [7:0] v);
    m[8'(199-8*(5*r+c)) -: 8] = v;
    return m;
  endfunction

  function automatic logic [199:0] diag5(input int d0, input int d1,
                                         input int d2, input int d3,
                                         input int d4);
    logic [199:0] m;
    m = '0;
    m = put(m, 0, 0, 8'(d0));
    m = put(m, 1, 1, 8'(d1));
    m = put(m, 2, 2, 8'(d2));
    m = put(m, 3, 3, 8'(d3));
    m = put(m, 4, 4, 8'(d4));
    return m;
  endfunction

  function automatic logic [199:0] rnd_mat();
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < 25; i++) m = put(m, i / 5, i % 5, 8'($urandom));
    return m;
  endfunction

  // Leibniz sum over permutations of the identity-padded matrix.
  function automatic logic [31:0] model(input logic [199:0] m, input int n);
    longint mm [5][5];
    longint sum;
    longint t;
    int     p [5];
    int     inv;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (r < n && c < n)
          mm[r][c] = longint'($signed(m[8'(199-8*(5*r+c)) -: 8]));
        else
          mm[r][c] = (r == c) ? 64'sd1 : 64'sd0;
    sum = 0;
    for (int a0 = 0; a0 < 5; a0++)
     for (int a1 = 0; a1 < 5; a1++)
      for (int a2 = 0; a2 < 5; a2++)
       for (int a3 = 0; a3 < 5; a3++)
        for (int a4 = 0; a4 < 5; a4++) begin
          if (((1 << a0) | (1 << a1) | (1 << a2) | (1 << a3) | (1 << a4))
              != 31) continue;
          p[0] = a0; p[1] = a1; p[2] = a2; p[3] = a3; p[4] = a4;
          inv = 0;
          for (int i = 0; i < 5; i++)
            for (int j = i + 1; j < 5; j++)
              if (p[i] > p[j]) inv++;
          t = 1;
          for (int i = 0; i < 5; i++) t = t * mm[i][p[i]];
          sum = (inv % 2 == 1) ? sum - t : sum + t;
        end
    return 32'(sum);
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (sb.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
      else                chk("det_out", det_out, sb.pop_front());
    end
  end

  task automatic issue(input logic [199:0] m, input logic [2:0] sz,
                       input logic [31:0] exp);
    matriz_in = m;
    size      = sz;
    start     = 1'b1;
    if (sz >= 3'd1 && sz <= 3'd5) sb.push_back(exp);
    @(negedge clk);
    start     = 1'b0;
    matriz_in = rnd_mat();
    size      = 3'($urandom);
  endtask

  task automatic wait_done(input int n0, input int exp_lat,
                           input string tag);
    int n;
    int b;
    n = n0;
    b = 0;
    while (!done && n < 30) begin
      if (busy) b++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy"}, 32'(b), 32'(exp_lat - n0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [199:0] m;
    logic [199:0] ident;
    logic [199:0] dg;
    int           nd;
    int           sz;

    ident = diag5(1, 1, 1, 1, 1);
    dg    = diag5(2, 3, -1, 4, 5);

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_det", det_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(ident, 3'd5, 32'd1);
    wait_done(1, 7, "id5");
    issue(dg, 3'd5, 32'hFFFF_FF88);
    wait_done(1, 7, "diag");
    issue(ident, 3'd5, 32'd1);
    wait_done(1, 7, "b2b");

    m = '1;
    for (int i = 0; i < 25; i++) m = put(m, i / 5, i % 5, 8'h7F);
    m = put(m, 0, 0, 8'd2); m = put(m, 0, 1, 8'd0); m = put(m, 0, 2, 8'd1);
    m = put(m, 1, 0, 8'd1); m = put(m, 1, 1, 8'd3); m = put(m, 1, 2, 8'd2);
    m = put(m, 2, 0, 8'd1); m = put(m, 2, 1, 8'd1); m = put(m, 2, 2, 8'd2);
    issue(m, 3'd3, 32'd6);
    wait_done(1, 3, "sz3");

    issue(diag5(127, 127, 127, 127, 127), 3'd5, 32'(-1321368961));
    wait_done(1, 7, "d127");

    for (int k = 0; k < 3; k++) begin
      sz = (k == 0) ? 6 : (k == 1) ? 0 : 7;
      issue(ident, 3'(sz), 32'd0);
      chk("err_pulse", {31'd0, error}, 32'd1);
      chk("err_busy", {31'd0, busy}, 32'd0);
      chk("err_done", {31'd0, done}, 32'd0);
      chk("err_det", det_out, 32'd0);
      @(negedge clk);
      chk("err_clear", {31'd0, error}, 32'd0);
    end

    issue(dg, 3'd5, 32'hFFFF_FF88);
    matriz_in = ident;
    size      = 3'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, 7, "ign");
    @(negedge clk);
    nd = n_done;
    repeat (10) @(negedge clk);
    chk("ign_nodone", 32'(n_done), 32'(nd));
    chk("ign_hold", det_out, 32'hFFFF_FF88);

    issue(ident, 3'd5, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_det", det_out, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    nd = n_done;
    repeat (10) @(negedge clk);
    chk("mrst_nodone", 32'(n_done), 32'(nd));
    issue(dg, 3'd5, 32'hFFFF_FF88);
    wait_done(1, 7, "post_rst");

    for (int k = 0; k < 1000; k++) begin
      sz = $urandom_range(1, 5);
      m  = rnd_mat();
      issue(m, 3'(sz), model(m, sz));
      wait_done(1, (sz == 5) ? 7 : 3, "rnd");
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
